// File: rtl/guess_game_core.sv
// guess_game_core: parametrised bulls-and-cows game core; `define GUESS_UNIQUE_DIGITS_EN to reject commits containing duplicate digits.
module guess_game_core #(
  parameter int NUM_DIGITS  = 4,
  parameter int MAX_DIGIT   = 9,
  parameter int MAX_TRIES   = 8,
  parameter int BLINK_TICKS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    btn_r,
  input  logic                    btn_l,
  input  logic                    btn_u,
  input  logic                    btn_d,
  input  logic                    tick,
  output logic [4*NUM_DIGITS-1:0] disp_val,
  output logic [NUM_DIGITS-1:0]   cursor,
  output logic [3:0]              tries,
  output logic                    win,
  output logic                    lose
);
  typedef enum logic [2:0] {IDLE, SET, GUESS, WRONG, CORRECT, LOSE} state_t;
  typedef logic [NUM_DIGITS-1:0][3:0] digs_t;
  localparam logic [NUM_DIGITS-1:0] MSB = {1'b1, {(NUM_DIGITS-1){1'b0}}};
  localparam logic [3:0] MD = 4'(MAX_DIGIT);
  localparam logic [3:0] MT = 4'(MAX_TRIES);
  localparam logic [3:0] BT = 4'(BLINK_TICKS);
  localparam digs_t DASH  = {NUM_DIGITS{4'd12}};
  localparam digs_t BLANK = {NUM_DIGITS{4'd13}};
  state_t state, state_n;
  digs_t dig, dig_n, sec, sec_n;
  logic [NUM_DIGITS-1:0] cur_n;
  logic [3:0] tries_n, tries_inc, cnt, cnt_n, bulls, cows;
  logic blank, blank_n, hit, dup;
  assign disp_val = dig;
  assign win  = state == CORRECT;
  assign lose = state == LOSE;
  assign tries_inc = (tries == MT) ? tries : tries + 4'd1;
  always_comb begin
    bulls = '0;
    cows  = '0;
    hit   = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hit = 1'b0;
      for (int j = 0; j < NUM_DIGITS; j++)
        if (j != i && dig[i] == sec[j]) hit = 1'b1;
      if (dig[i] == sec[i]) bulls = bulls + 4'd1;
      else if (hit) cows = cows + 4'd1;
    end
  end
`ifdef GUESS_UNIQUE_DIGITS_EN
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++)
      for (int j = i + 1; j < NUM_DIGITS; j++)
        if (dig[i] == dig[j]) dup = 1'b1;
  end
`else
  assign dup = 1'b0;
`endif
  always_comb begin
    state_n = state;
    dig_n   = dig;
    sec_n   = sec;
    cur_n   = cursor;
    tries_n = tries;
    cnt_n   = cnt;
    blank_n = blank;
    case (state)
      IDLE: if (btn_r) begin
        state_n = SET;
        dig_n   = '0;
        cur_n   = MSB;
        tries_n = '0;
      end
      SET, GUESS: begin
        if (btn_l) begin
          state_n = IDLE;
          dig_n   = DASH;
          cur_n   = '0;
        end else if (btn_r && !cursor[0]) begin
          cur_n = cursor >> 1;
        end else if (btn_r && dup) begin
          cur_n = MSB;
        end else if (btn_r && state == SET) begin
          sec_n   = dig;
          state_n = GUESS;
          dig_n   = '0;
          cur_n   = MSB;
        end else if (btn_r && bulls == 4'(NUM_DIGITS)) begin
          state_n = CORRECT;
          cur_n   = '0;
          cnt_n   = '0;
          blank_n = 1'b0;
        end else if (btn_r) begin
          tries_n = tries_inc;
          cur_n   = '0;
          cnt_n   = '0;
          state_n = (tries_inc == MT) ? LOSE : WRONG;
          dig_n   = (tries_inc == MT) ? sec : DASH;
          if (tries_inc != MT) begin
            dig_n[3] = bulls;
            dig_n[2] = 4'd10;
            dig_n[1] = cows;
            dig_n[0] = 4'd11;
          end
        end else if (btn_u || btn_d) begin
          for (int i = 0; i < NUM_DIGITS; i++)
            if (cursor[i])
              dig_n[i] = btn_u ? ((dig[i] == MD) ? 4'd0 : dig[i] + 4'd1)
                               : ((dig[i] == 4'd0) ? MD : dig[i] - 4'd1);
        end
      end
      WRONG: begin
        if (btn_l) begin
          state_n = IDLE;
          dig_n   = DASH;
        end else if (btn_r) begin
          state_n = GUESS;
          dig_n   = '0;
          cur_n   = MSB;
        end
      end
      CORRECT: if (tick) begin
        cnt_n   = cnt + 4'd1;
        blank_n = ~blank;
        state_n = (cnt_n == BT) ? IDLE : CORRECT;
        dig_n   = (cnt_n == BT) ? DASH : (blank ? sec : BLANK);
      end
      LOSE: if (tick) begin
        cnt_n = cnt + 4'd1;
        if (cnt_n == BT) begin
          state_n = IDLE;
          dig_n   = DASH;
          tries_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      dig    <= DASH;
      sec    <= '0;
      cursor <= '0;
      tries  <= '0;
      cnt    <= '0;
      blank  <= 1'b0;
    end else begin
      state  <= state_n;
      dig    <= dig_n;
      sec    <= sec_n;
      cursor <= cur_n;
      tries  <= tries_n;
      cnt    <= cnt_n;
      blank  <= blank_n;
    end
  end
endmodule

// File: tb/tb_guess_game_core.sv
// tb_guess_game_core: scoreboard bench; stimulus queues expected outputs, monitor compares them.
module tb_guess_game_core;
  logic clk = 0, rst = 0, btn_r = 0, btn_l = 0, btn_u = 0, btn_d = 0, tick = 0;
  logic [15:0] disp_val;
  logic [3:0] cursor, tries;
  logic win, lose, obs = 0;
  int total = 0, bad = 0;
  logic [25:0] exp_q[$];
  string name_q[$];
  localparam logic [5:0] RST = 6'b100000, L = 6'b010000, R = 6'b001000,
                         U = 6'b000100, D = 6'b000010, T = 6'b000001;
  guess_game_core #(.NUM_DIGITS(4), .MAX_DIGIT(9), .MAX_TRIES(2), .BLINK_TICKS(5)) dut (
    .clk(clk), .rst(rst), .btn_r(btn_r), .btn_l(btn_l), .btn_u(btn_u), .btn_d(btn_d),
    .tick(tick), .disp_val(disp_val), .cursor(cursor), .tries(tries), .win(win), .lose(lose)
  );
  always #5 clk = ~clk;
  function automatic logic [25:0] e(input logic [15:0] d, input logic [3:0] c, input logic [3:0] t,
                                    input logic w, input logic l);
    return {d, c, t, w, l};
  endfunction
  task automatic act(input logic [5:0] b, input bit chk, input string nm, input logic [25:0] x);
    @(posedge clk); #2;
    {rst, btn_l, btn_r, btn_u, btn_d, tick} = b;
    @(posedge clk); #2;
    {rst, btn_l, btn_r, btn_u, btn_d, tick} = '0;
    if (chk) begin
      exp_q.push_back(x);
      name_q.push_back(nm);
      obs = 1;
    end
    @(posedge clk); #2;
    obs = 0;
  endtask
  task automatic press(input logic [5:0] b);
    act(b, 0, "", '0);
  endtask
  task automatic enter4(input logic [15:0] v);
    for (int i = 3; i >= 0; i--) begin
      for (int k = 0; k < int'(v[4*i +: 4]); k++) press(U);
      if (i > 0) press(R);
    end
  endtask
  always @(negedge clk) begin
    if (obs) begin
      logic [25:0] got, x;
      string nm;
      got = {disp_val, cursor, tries, win, lose};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty got=%h", got);
      end else begin
        x = exp_q.pop_front();
        nm = name_q.pop_front();
        if (got !== x) begin
          bad++;
          $display("FAIL %s got disp=%h cur=%b tries=%0d win=%b lose=%b, want disp=%h cur=%b tries=%0d win=%b lose=%b",
                   nm, got[25:10], got[9:6], got[5:2], got[1], got[0], x[25:10], x[9:6], x[5:2], x[1], x[0]);
        end
      end
    end
  end
  initial begin
    act(RST, 1, "reset", e(16'hCCCC, 4'b0000, 0, 0, 0));
    act(R, 1, "enter_set", e(16'h0000, 4'b1000, 0, 0, 0));
    act(D, 1, "dec_wrap", e(16'h9000, 4'b1000, 0, 0, 0));
    act(U, 1, "inc_wrap", e(16'h0000, 4'b1000, 0, 0, 0));
    enter4(16'h1230);
    act(D, 1, "dec_d0", e(16'h1239, 4'b0001, 0, 0, 0));
    act(U, 1, "inc_d0", e(16'h1230, 4'b0001, 0, 0, 0));
    repeat (4) press(U);
    act(R, 1, "commit_set", e(16'h0000, 4'b1000, 0, 0, 0));
    enter4(16'h1243);
    act(T, 1, "guess_entry", e(16'h1243, 4'b0001, 0, 0, 0));
    act(R, 1, "wrong1", e(16'h2A2B, 4'b0000, 1, 0, 0));
    act(R, 1, "wrong_to_guess", e(16'h0000, 4'b1000, 1, 0, 0));
    act(U | D, 1, "prio_ud", e(16'h1000, 4'b1000, 1, 0, 0));
    press(R); press(U); press(U); press(R); repeat (3) press(U); press(R); repeat (4) press(U);
    act(R, 1, "correct", e(16'h1234, 4'b0000, 1, 1, 0));
    act(R | U, 1, "ignore_btn", e(16'h1234, 4'b0000, 1, 1, 0));
    act(T, 1, "blink1", e(16'hDDDD, 4'b0000, 1, 1, 0));
    act(T, 1, "blink2", e(16'h1234, 4'b0000, 1, 1, 0));
    act(T, 1, "blink3", e(16'hDDDD, 4'b0000, 1, 1, 0));
    act(T, 1, "blink4", e(16'h1234, 4'b0000, 1, 1, 0));
    act(T, 1, "blink_exit", e(16'hCCCC, 4'b0000, 1, 0, 0));
    act(R, 1, "set_again", e(16'h0000, 4'b1000, 0, 0, 0));
    enter4(16'h1234);
    press(R);
    repeat (3) press(R);
    act(R, 1, "wrong_a", e(16'h0A0B, 4'b0000, 1, 0, 0));
    press(R);
    repeat (3) press(R);
    act(R, 1, "lose", e(16'h1234, 4'b0000, 2, 0, 1));
    repeat (3) press(T);
    act(T, 1, "lose_hold", e(16'h1234, 4'b0000, 2, 0, 1));
    act(T, 1, "lose_exit", e(16'hCCCC, 4'b0000, 0, 0, 0));
    press(R);
    repeat (3) press(R);
    act(R, 1, "guess_0000", e(16'h0000, 4'b1000, 0, 0, 0));
    act(L | R, 1, "prio_lr", e(16'hCCCC, 4'b0000, 0, 0, 0));
    press(R);
    repeat (4) press(R);
    repeat (3) press(R);
    act(R, 1, "correct2", e(16'h0000, 4'b0000, 0, 1, 0));
    act(RST, 1, "rst_mid", e(16'hCCCC, 4'b0000, 0, 0, 0));
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
